// File: rtl/pc_ctrl_if.sv
// Fetch-stage bus between decode/branch-compare and the PC controller.
// Signal prefixes are from the controller's point of view.
interface pc_ctrl_if #(
    parameter int XLEN = 32
);
    logic [6:0]      i_op;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_rs1_data;
    logic            i_b_taken;
    logic            i_hold;
    logic [XLEN-1:0] o_ip;
    logic [XLEN-1:0] o_pc_def;
    logic            o_fetch_valid;
    logic            o_misalign;
    logic            o_busy;

    modport master (
        output i_op, i_imm, i_rs1_data, i_b_taken, i_hold,
        input  o_ip, o_pc_def, o_fetch_valid, o_misalign, o_busy
    );

    modport slave (
        input  i_op, i_imm, i_rs1_data, i_b_taken, i_hold,
        output o_ip, o_pc_def, o_fetch_valid, o_misalign, o_busy
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential fetch, stalled branch resolution,
// JALR target formation and misaligned-target trapping.
module pc_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
    parameter int              BR_STALL  = 1,
    parameter bit              C_EXT     = 1'b0
) (
    input logic         i_clk,
    input logic         i_reset_n,
    pc_ctrl_if.slave    bus
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_REDIRECT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_ip, w_ip_nxt;
    logic [XLEN-1:0] r_tgt, w_tgt_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic            r_jmp, w_jmp_nxt;
    logic            r_mis, w_mis_nxt;

    logic [XLEN-1:0] w_ip_inc;
    logic [XLEN-1:0] w_rel_tgt;
    logic [XLEN-1:0] w_jalr_tgt;
    logic            w_tgt_mis;
    logic            w_taken;

    assign w_ip_inc   = r_ip + XLEN'(4);
    assign w_rel_tgt  = r_ip + bus.i_imm;
    assign w_jalr_tgt = (bus.i_rs1_data + bus.i_imm) & ~XLEN'(1);
    // With C_EXT=0 any nonzero low two bits trap; with C_EXT only bit 0 does.
    assign w_tgt_mis  = C_EXT ? r_tgt[0] : (r_tgt[1] | r_tgt[0]);
    assign w_taken    = r_jmp | bus.i_b_taken;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_ip_nxt    = r_ip;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        w_jmp_nxt   = r_jmp;
        w_mis_nxt   = 1'b0;
        if (!bus.i_hold) begin
            unique case (r_state)
                S_RUN: begin
                    if (bus.i_op == OP_JAL || bus.i_op == OP_JALR || bus.i_op == OP_BRANCH) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 3'(BR_STALL - 1);
                        w_tgt_nxt   = (bus.i_op == OP_JALR) ? w_jalr_tgt : w_rel_tgt;
                        w_jmp_nxt   = (bus.i_op != OP_BRANCH);
                    end else begin
                        w_ip_nxt = w_ip_inc;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 3'd0) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end else if (!w_taken) begin
                        w_ip_nxt    = w_ip_inc;
                        w_state_nxt = S_RUN;
                    end else if (w_tgt_mis) begin
                        w_ip_nxt    = TRAP_VEC;
                        w_mis_nxt   = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_ip_nxt    = r_tgt;
                        w_state_nxt = S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    w_ip_nxt    = w_ip_inc;
                    w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // NOTE: reset is synchronous and sits above HOLD, so it always wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_RUN;
            r_ip    <= RESET_VEC;
            r_tgt   <= '0;
            r_cnt   <= 3'd0;
            r_jmp   <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ip    <= w_ip_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_jmp   <= w_jmp_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    assign bus.o_ip          = r_ip;
    assign bus.o_pc_def      = w_ip_inc;
    assign bus.o_fetch_valid = (r_state != S_WAIT);
    assign bus.o_busy        = (r_state != S_RUN);
    assign bus.o_misalign    = r_mis;
endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_ctrl;
    localparam int          XLEN      = 64;
    localparam logic [63:0] RESET_VEC = 64'h0;
    localparam logic [63:0] TRAP_VEC  = 64'h100;
    localparam int          BR_STALL  = 2;
    localparam bit          C_EXT     = 1'b0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SEQ    = 7'b0010011;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    pc_ctrl_if #(.XLEN(XLEN)) bus ();

    pc_ctrl #(
        .XLEN(XLEN), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC),
        .BR_STALL(BR_STALL), .C_EXT(C_EXT)
    ) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: wait_left counts WAIT cycles still to come (0 = not waiting).
    logic [63:0] m_ip = RESET_VEC;
    logic [63:0] m_tgt = '0;
    int          m_wait_left = 0;
    bit          m_redirect = 1'b0;
    bit          m_jump = 1'b0;
    bit          m_mis = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [6:0] op, input logic [63:0] imm, input logic [63:0] rs1,
                              input bit bt, input bit hold, input bit rst_n);
        bit mis_tgt;
        if (!rst_n) begin
            m_ip = RESET_VEC; m_tgt = '0; m_wait_left = 0;
            m_redirect = 0; m_jump = 0; m_mis = 0;
        end else begin
            m_mis = 0;
            if (hold) begin
                // everything frozen
            end else if (m_redirect) begin
                m_redirect = 0;
                m_ip = m_ip + 64'd4;
            end else if (m_wait_left > 1) begin
                m_wait_left--;
            end else if (m_wait_left == 1) begin
                m_wait_left = 0;
                mis_tgt = C_EXT ? m_tgt[0] : (m_tgt[1:0] != 2'b00);
                if (!(m_jump || bt)) m_ip = m_ip + 64'd4;
                else if (mis_tgt) begin
                    m_ip = TRAP_VEC;
                    m_mis = 1;
                end else begin
                    m_ip = m_tgt;
                    m_redirect = 1;
                end
            end else if (op == OP_JAL || op == OP_BRANCH) begin
                m_tgt = m_ip + imm;
                m_wait_left = BR_STALL;
                m_jump = (op == OP_JAL);
            end else if (op == OP_JALR) begin
                m_tgt = (rs1 + imm) & ~64'd1;
                m_wait_left = BR_STALL;
                m_jump = 1;
            end else begin
                m_ip = m_ip + 64'd4;
            end
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [63:0] imm, input logic [63:0] rs1,
                        input bit bt, input bit hold, input bit rst_n);
        bus.i_op       = op;
        bus.i_imm      = imm;
        bus.i_rs1_data = rs1;
        bus.i_b_taken  = bt;
        bus.i_hold     = hold;
        reset_n        = rst_n;
        @(posedge clk);
        model_edge(op, imm, rs1, bt, hold, rst_n);
        #1;
        check("ip", bus.o_ip, m_ip);
        check("pc_def", bus.o_pc_def, m_ip + 64'd4);
        check("fetch_valid", 64'(bus.o_fetch_valid), 64'(m_wait_left == 0));
        check("busy", 64'(bus.o_busy), 64'(m_wait_left != 0 || m_redirect));
        check("misalign", 64'(bus.o_misalign), 64'(m_mis));
    endtask

    task automatic seq();
        step(OP_SEQ, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // WAIT cycles before the resolve cycle carry the opposite B_TAKEN, which must be ignored.
    task automatic resolve(input bit bt);
        for (int i = 0; i < BR_STALL - 1; i++) step(OP_JAL, 64'd0, 64'd0, !bt, 1'b0, 1'b1);
        step(OP_JAL, 64'd0, 64'd0, bt, 1'b0, 1'b1);
    endtask

    initial begin
        bus.i_op = OP_SEQ; bus.i_imm = '0; bus.i_rs1_data = '0;
        bus.i_b_taken = 1'b0; bus.i_hold = 1'b1; reset_n = 1'b0;

        // Reset with HOLD asserted, then sequential fetch.
        step(OP_JAL, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
        step(OP_JAL, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
        check("rst_ip_fixed", bus.o_ip, 64'h0);
        check("rst_fv_fixed", 64'(bus.o_fetch_valid), 64'd1);
        seq(); seq(); seq();
        check("seq_ip_fixed", bus.o_ip, 64'hC);
        seq();

        // Taken branch from 0x10 to 0x30.
        step(OP_BRANCH, 64'h20, 64'd0, 1'b0, 1'b0, 1'b1);
        check("br_wait_fixed", 64'(bus.o_fetch_valid), 64'd0);
        resolve(1'b1);
        check("br_taken_fixed", bus.o_ip, 64'h30);
        seq();
        check("br_after_fixed", bus.o_ip, 64'h34);

        // Not-taken branch falls through.
        step(OP_BRANCH, 64'h20, 64'd0, 1'b0, 1'b0, 1'b1);
        resolve(1'b0);
        check("br_nt_fixed", bus.o_ip, 64'h38);

        // JALR aligned, then JALR misaligned into the trap vector.
        step(OP_JALR, 64'd4, 64'h1001, 1'b0, 1'b0, 1'b1);
        resolve(1'b0);
        check("jalr_fixed", bus.o_ip, 64'h1004);
        seq();
        step(OP_JALR, 64'd4, 64'h1003, 1'b0, 1'b0, 1'b1);
        resolve(1'b0);
        check("trap_ip_fixed", bus.o_ip, TRAP_VEC);
        check("trap_mis_fixed", 64'(bus.o_misalign), 64'd1);
        seq();
        check("trap_pulse_fixed", 64'(bus.o_misalign), 64'd0);

        // HOLD in the middle of WAIT delays resolution.
        step(OP_BRANCH, 64'h40, 64'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(OP_SEQ, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1);
        resolve(1'b1);
        seq();

        // Reset in the middle of WAIT drops the pending jump.
        step(OP_JAL, 64'h80, 64'd0, 1'b0, 1'b0, 1'b1);
        step(OP_SEQ, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("rst_wait_fixed", bus.o_ip, 64'h0);
        seq();
        check("rst_norun_fixed", bus.o_ip, 64'h4);

        // Wrap at the top of the 64-bit space, then JAL backwards to 0.
        step(OP_JALR, 64'd4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b1);
        resolve(1'b0);
        check("top_fixed", bus.o_ip, 64'hFFFF_FFFF_FFFF_FFFC);
        seq();
        check("wrap_fixed", bus.o_ip, 64'h0);
        seq(); seq();
        step(OP_JAL, -64'sd8, 64'd0, 1'b0, 1'b0, 1'b1);
        resolve(1'b0);
        check("jal_neg_fixed", bus.o_ip, 64'h0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0]  op;
            logic [63:0] imm;
            logic [63:0] rs1;
            int          sel;
            int          off;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      op = OP_JAL;
            else if (sel == 1) op = OP_JALR;
            else if (sel == 2) op = OP_BRANCH;
            else begin
                op = 7'($urandom);
                if (op == OP_JAL || op == OP_JALR || op == OP_BRANCH) op = OP_SEQ;
            end
            off = (int'($urandom_range(0, 1023)) - 512) * 2;
            imm = 64'(longint'(off));
            rs1 = {$urandom, $urandom};
            step(op, imm, rs1, 1'($urandom), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller for the RV32I/RV64I fetch stage. It generates the fetch address, adds a configurable branch-resolution stall depth, and computes correct JALR targets (RS1+IMM, bit 0 cleared). It also supports an external pipeline hold and traps misaligned control-transfer targets. It sits between decode (OP, IMM, RS1_DATA), the branch comparator (B_TAKEN) and the instruction memory address port.

Parameters:
XLEN, 32, address/data width (32 or 64)
RESET_VEC, 0, IP value after reset
TRAP_VEC, 'h100, IP loaded on a misaligned taken target
BR_STALL, 1, wait cycles before B_TAKEN is sampled (1..4)
C_EXT, 0, 1 = 2-byte alignment allowed, 0 = 4-byte alignment required

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET_N  in  1  synchronous active-low reset
OP  in  7  opcode of the instruction currently in decode
IMM  in  XLEN  signed, sign-extended immediate of that instruction
RS1_DATA  in  XLEN  rs1 operand, used for JALR
B_TAKEN  in  1  branch outcome, sampled only on the last WAIT cycle
HOLD  in  1  external stall; freezes all state
IP  out  XLEN  current fetch address (registered)
PC_DEF  out  XLEN  IP+4, combinational, mod 2^XLEN
FETCH_VALID  out  1  1 when IP is a fetch to consume; 0 in WAIT
MISALIGN  out  1  one-cycle pulse when a taken target is misaligned
BUSY  out  1  1 in WAIT or REDIRECT

Behaviour:
- Reset (RESET_N=0 at edge) dominates everything, including HOLD: IP=RESET_VEC, state RUN, counter=0, TGT=0, pending-jump flag=0, MISALIGN=0. After reset FETCH_VALID=1 and BUSY=0.
- Reset mid-WAIT or mid-REDIRECT discards the captured target.
- Opcode classes: JAL=1101111, JALR=1100111, BRANCH=1100011. Every other opcode is sequential.
- States: RUN, WAIT, REDIRECT.
- HOLD=1, any state: IP, state, counter and TGT are unchanged, and MISALIGN=0.
- RUN, sequential OP: IP <= IP+4.
- RUN, control OP:
  - IP is held and state goes to WAIT.
  - counter <= BR_STALL-1.
  - TGT is captured on the same edge: JAL/BRANCH -> IP+IMM; JALR -> (RS1_DATA+IMM) with bit 0 cleared.
  - The pending-jump flag is set for JAL/JALR and cleared for BRANCH.
- WAIT:
  - OP is ignored. FETCH_VALID=0.
  - If counter!=0: decrement.
  - If counter==0, the resolve cycle:
    - taken = jump flag OR B_TAKEN.
    - Not taken -> IP <= IP+4, state RUN.
    - Taken and aligned -> IP <= TGT, state REDIRECT.
    - Taken and misaligned (TGT[1] with C_EXT=0; TGT[0] is always 0 after the JALR clear) -> IP <= TRAP_VEC, MISALIGN=1 for exactly the next cycle, state RUN.
- REDIRECT:
  - One cycle. OP is ignored (squashes the wrong-path instruction). FETCH_VALID=1.
  - Next edge: IP <= IP+4, state RUN.
- B_TAKEN outside the resolve cycle has no effect.
- All additions wrap mod 2^XLEN: IP=all-ones minus 3 in RUN -> IP=0.
- Branch latency from control OP in RUN to the target on IP is BR_STALL+1 cycles.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with HOLD=1 -> IP=0, FETCH_VALID=1, BUSY=0; then 3 cycles of sequential OP -> IP=4, 8, 0xC.
- Taken branch (BR_STALL=1): IP=0x10, OP=BRANCH, IMM=0x20. Next cycle IP=0x10, FETCH_VALID=0; drive B_TAKEN=1. Next IP=0x30 (REDIRECT), then 0x34.
- Not-taken branch: same stimulus, B_TAKEN=0 -> IP goes 0x10, 0x10, 0x14, 0x18. With BR_STALL=3 the WAIT lasts 3 cycles before 0x14.
- JALR: IP=0x40, RS1_DATA=0x1001, IMM=4, OP=JALR, B_TAKEN=0 -> IP=0x1004 after WAIT. With RS1_DATA=0x1003 and C_EXT=0 -> IP=TRAP_VEC (0x100), MISALIGN=1 for one cycle.
- HOLD mid-WAIT: BR_STALL=2, HOLD=1 for 3 cycles during WAIT -> IP and counter frozen, resolve delayed 3 cycles. RESET_N=0 mid-WAIT -> IP=0, state RUN, no redirect.
- Wrap and width: XLEN=64, IP=0xFFFF_FFFF_FFFF_FFFC with a sequential OP -> IP=0. JAL with IMM=-8 at IP=0x8 -> IP=0x0.
